commutation_sequencer: RTL and testbench
========================================

Name: commutation_sequencer

Overview:
- Parametrised multi-step commutation sequencer for the MPC bidirectional switch array.
- Drives the switch-gate vector `vout` for NSW bidirectional switches. Each switch is a pair of devices, so the vector is 2*NSW bits wide.
- On a change of requested vector it walks a current-direction-safe 3-step overlap sequence with programmable dwell per step, then commits the new vector.
- Generalises the fixed 6-bit, single-direction, live-input sequencer:
  - per-switch current direction;
  - latched target, direction and dwell;
  - dwell counter;
  - busy/done status;
  - synchronous reset.

Parameters:
- NSW, 3: number of bidirectional switches; vector width W = 2*NSW.
- DWELL_W, 8: width of the dwell input and the internal dwell counter.
- INIT_VEC, W'b000011 (low pair on for NSW=3): vector applied and committed out of reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- vnew  in  W  requested switch vector; pair i = bits {2i+1, 2i}.
- dir  in  NSW  current direction per switch; 0 = keep even device (bit 2i), 1 = keep odd device (bit 2i+1).
- dwell  in  DWELL_W  step hold length; each step lasts dwell+1 cycles.
- vout  out  W  registered gate vector to the switch drivers.
- vcur  out  W  committed (last completed) vector.
- busy  out  1  high while a sequence is in progress (states STEP1..STEP3).
- done  out  1  one-cycle pulse in the cycle the new vector is committed.

Behaviour:
- Reset (rst=1 at an edge, any state):
  - state=IDLE; vout=INIT_VEC; vcur=INIT_VEC.
  - busy=0, done=0, counter=0.
  - Any sequence in progress is abandoned; no done pulse is issued.
- Mask M, built per pair at sequence start: M[2i+1:2i] = dir[i] ? 2'b10 : 2'b01.
- FSM states: IDLE, STEP1, STEP2, STEP3. All outputs are registered.
- IDLE:
  - vout=vcur, busy=0.
  - If vnew != vcur at an edge:
    - latch vtgt<=vnew, M<=mask(dir), cnt<=dwell;
    - go to STEP1; vout<=vcur & M; busy<=1.
  - If vnew == vcur: stay in IDLE, no activity.
- STEP1: vout = vcur & M (outgoing conducting devices only).
- STEP2: vout = (vcur | vtgt) & M (overlap of outgoing and incoming conducting devices).
- STEP3: vout = vtgt & M (incoming conducting devices only).
- Step advance:
  - In each STEPn, if cnt==0 at an edge, move to the next state and reload cnt<=latched dwell; otherwise cnt<=cnt-1.
  - Therefore every step is held exactly dwell+1 cycles. dwell=0 gives 1 cycle per step.
- Leaving STEP3 (cnt==0):
  - state=IDLE; vout<=vtgt; vcur<=vtgt.
  - done<=1 for exactly that one cycle; busy<=0.
- Latency:
  - Request sampled at edge k → STEP1 output visible after edge k.
  - Final vector visible after edge k + 3*(dwell+1).
- Latching:
  - vnew, dir and dwell are latched at sequence start.
  - Changes to them during STEP1..STEP3 are ignored.
- Back-to-back requests:
  - In the IDLE cycle after done, vnew is compared against the new vcur. A differing vnew starts the next sequence immediately; no extra idle cycle is required beyond that one IDLE cycle.
- Pairs whose bits are identical in vcur and vtgt still follow the mask each step. This is intended: non-conducting devices are blanked for the sequence.
- dwell at maximum (all ones): counter must not wrap incorrectly; each step lasts 2^DWELL_W cycles.
- No combinational path from any input to vout.

Test Plan:
- Reset (NSW=3, INIT_VEC=000011): assert rst 2 cycles →
  - vout=000011, vcur=000011, busy=0, done=0.
  - Holding vnew=000011 → no sequence starts.
- dwell=0, dir=000, vnew=001100 →
  - vout on successive cycles: 000001, 000101, 000100, 001100.
  - busy=1 for 3 cycles; done=1 coincident with 001100; vcur=001100.
- dwell=2, dir=111, from vcur=000011 to vnew=001100 →
  - vout: 000010 ×3, 001010 ×3, 001000 ×3, then 001100 with done=1.
- Mixed dir=010 (M=011001), dwell=0, vcur=000011, vnew=110000 →
  - vout: 000001, 010001, 010000, 110000.
- Mid-sequence changes: start 000011→001100 with dwell=1. During STEP2, change vnew to 110000 and dir to 111 →
  - current sequence completes to 001100 with the original mask; done pulses;
  - one IDLE cycle follows;
  - a new sequence toward 110000 starts using M=101010.
- Reset mid-sequence: assert rst while in STEP2 →
  - next cycle vout=000011, vcur=000011, busy=0;
  - no done pulse;
  - sequence does not resume after rst is released unless vnew != 000011.

Source files
------------

// File: rtl/commutation_sequencer_if.sv
// Handshake bundle between a controller and the commutation sequencer.
//   vnew  : requested switch vector, pair i = bits {2i+1, 2i}
//   dir   : per-switch current direction (0 keeps even device, 1 keeps odd)
//   dwell : step hold length, each step lasts dwell+1 cycles
//   vout  : registered gate vector to the switch drivers
//   vcur  : committed (last completed) vector
//   busy  : sequence in progress
//   done  : one-cycle pulse when the new vector is committed
interface commutation_sequencer_if #(
  parameter int NSW     = 3,
  parameter int DWELL_W = 8
);
  logic [2*NSW-1:0]   vnew;
  logic [NSW-1:0]     dir;
  logic [DWELL_W-1:0] dwell;
  logic [2*NSW-1:0]   vout;
  logic [2*NSW-1:0]   vcur;
  logic               busy;
  logic               done;

  modport master (output vnew, dir, dwell, input vout, vcur, busy, done);
  modport slave  (input vnew, dir, dwell, output vout, vcur, busy, done);
endinterface

// File: rtl/commutation_sequencer.sv
// Multi-step commutation sequencer for an MPC bidirectional switch array.
// On a change of requested vector it walks a current-direction-safe
// 3-step overlap (outgoing only, overlap, incoming only), each step held
// dwell+1 cycles, then commits the new vector.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : commutation_sequencer_if.slave (vnew/dir/dwell in,
//         vout/vcur/busy/done out, all outputs registered)
module commutation_sequencer #(
  parameter int               NSW      = 3,
  parameter int               DWELL_W  = 8,
  parameter logic [2*NSW-1:0] INIT_VEC = (2*NSW)'(3)
) (
  input  logic                    clk,
  input  logic                    rst,
  commutation_sequencer_if.slave  bus
);
  localparam int W = 2*NSW;

  typedef enum logic [1:0] {IDLE, STEP1, STEP2, STEP3} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [W-1:0]       vtgt;
  logic [W-1:0]       mask;
  logic [W-1:0]       mask_new;
  logic [W-1:0]       vout;
  logic [W-1:0]       vcur;
  logic               busy;
  logic               done;
  logic               step_end;

  // Keep only the device that conducts in the present current direction.
  always_comb begin
    mask_new = '0;
    for (int i = 0; i < NSW; i++)
      mask_new[2*i +: 2] = bus.dir[i] ? 2'b10 : 2'b01;
  end

  // Counter counts down from the latched dwell; zero ends the step, so a
  // full-scale dwell gives 2^DWELL_W cycles without any wrap concern.
  assign step_end = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vout    <= INIT_VEC;
      vcur    <= INIT_VEC;
      vtgt    <= INIT_VEC;
      mask    <= '0;
      cnt     <= '0;
      dwell_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.vnew != vcur) begin
            vtgt    <= bus.vnew;
            mask    <= mask_new;
            cnt     <= bus.dwell;
            dwell_q <= bus.dwell;
            vout    <= vcur & mask_new;
            busy    <= 1'b1;
            state   <= STEP1;
          end
        end
        STEP1: begin
          if (step_end) begin
            cnt   <= dwell_q;
            vout  <= (vcur | vtgt) & mask;
            state <= STEP2;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        STEP2: begin
          if (step_end) begin
            cnt   <= dwell_q;
            vout  <= vtgt & mask;
            state <= STEP3;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        STEP3: begin
          if (step_end) begin
            cnt   <= dwell_q;
            vout  <= vtgt;
            vcur  <= vtgt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vout = vout;
  assign bus.vcur = vcur;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: tb/tb_commutation_sequencer.sv
module tb_commutation_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  commutation_sequencer_if #(.NSW(3), .DWELL_W(8)) bus ();

  commutation_sequencer #(
    .NSW(3), .DWELL_W(8), .INIT_VEC(6'b000011)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic       rst;
    logic [5:0] vnew;
    logic [2:0] dir;
    logic [7:0] dwell;
    logic [5:0] vout;
    logic [5:0] vcur;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(string tag, int n, logic r, logic [5:0] vn,
                              logic [2:0] d, logic [7:0] dw, logic [5:0] vo,
                              logic [5:0] vc, logic b, logic dn);
    vec_t v;
    v.tag = tag; v.rst = r; v.vnew = vn; v.dir = d; v.dwell = dw;
    v.vout = vo; v.vcur = vc; v.busy = b; v.done = dn;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  initial begin
    vec_t e;
    bit   seen;
    bus.vnew = 6'b000011; bus.dir = 3'b000; bus.dwell = 8'd0;

    add("rst",       2, 1, 6'b000011, 3'b000, 8'd0, 6'b000011, 6'b000011, 0, 0);
    add("hold",      3, 0, 6'b000011, 3'b000, 8'd0, 6'b000011, 6'b000011, 0, 0);
    add("d0_s1",     1, 0, 6'b001100, 3'b000, 8'd0, 6'b000001, 6'b000011, 1, 0);
    add("d0_s2",     1, 0, 6'b001100, 3'b000, 8'd0, 6'b000101, 6'b000011, 1, 0);
    add("d0_s3",     1, 0, 6'b001100, 3'b000, 8'd0, 6'b000100, 6'b000011, 1, 0);
    add("d0_done",   1, 0, 6'b001100, 3'b000, 8'd0, 6'b001100, 6'b001100, 0, 1);
    add("d0_idle",   2, 0, 6'b001100, 3'b000, 8'd0, 6'b001100, 6'b001100, 0, 0);
    add("rst2",      1, 1, 6'b000011, 3'b000, 8'd0, 6'b000011, 6'b000011, 0, 0);
    add("d2_s1a",    1, 0, 6'b001100, 3'b111, 8'd2, 6'b000010, 6'b000011, 1, 0);
    add("d2_s1",     2, 0, 6'b001100, 3'b000, 8'd0, 6'b000010, 6'b000011, 1, 0);
    add("d2_s2",     3, 0, 6'b001100, 3'b000, 8'd0, 6'b001010, 6'b000011, 1, 0);
    add("d2_s3",     3, 0, 6'b001100, 3'b000, 8'd0, 6'b001000, 6'b000011, 1, 0);
    add("d2_done",   1, 0, 6'b001100, 3'b000, 8'd0, 6'b001100, 6'b001100, 0, 1);
    add("d2_idle",   1, 0, 6'b001100, 3'b000, 8'd0, 6'b001100, 6'b001100, 0, 0);
    add("rst3",      1, 1, 6'b000011, 3'b000, 8'd0, 6'b000011, 6'b000011, 0, 0);
    add("mix_s1",    1, 0, 6'b110000, 3'b010, 8'd0, 6'b000001, 6'b000011, 1, 0);
    add("mix_s2",    1, 0, 6'b110000, 3'b010, 8'd0, 6'b010001, 6'b000011, 1, 0);
    add("mix_s3",    1, 0, 6'b110000, 3'b010, 8'd0, 6'b010000, 6'b000011, 1, 0);
    add("mix_done",  1, 0, 6'b110000, 3'b010, 8'd0, 6'b110000, 6'b110000, 0, 1);
    add("mix_idle",  1, 0, 6'b110000, 3'b010, 8'd0, 6'b110000, 6'b110000, 0, 0);
    add("rst4",      1, 1, 6'b000011, 3'b000, 8'd1, 6'b000011, 6'b000011, 0, 0);
    add("mid_s1",    2, 0, 6'b001100, 3'b000, 8'd1, 6'b000001, 6'b000011, 1, 0);
    add("mid_s2a",   1, 0, 6'b001100, 3'b000, 8'd1, 6'b000101, 6'b000011, 1, 0);
    add("mid_s2b",   1, 0, 6'b110000, 3'b111, 8'd1, 6'b000101, 6'b000011, 1, 0);
    add("mid_s3",    2, 0, 6'b110000, 3'b111, 8'd1, 6'b000100, 6'b000011, 1, 0);
    add("mid_done",  1, 0, 6'b110000, 3'b111, 8'd1, 6'b001100, 6'b001100, 0, 1);
    add("mid2_s1",   2, 0, 6'b110000, 3'b111, 8'd1, 6'b001000, 6'b001100, 1, 0);
    add("mid2_s2",   2, 0, 6'b110000, 3'b111, 8'd1, 6'b101000, 6'b001100, 1, 0);
    add("mid2_s3",   2, 0, 6'b110000, 3'b111, 8'd1, 6'b100000, 6'b001100, 1, 0);
    add("mid2_done", 1, 0, 6'b110000, 3'b111, 8'd1, 6'b110000, 6'b110000, 0, 1);
    add("mid2_idle", 1, 0, 6'b110000, 3'b111, 8'd1, 6'b110000, 6'b110000, 0, 0);
    add("rst5",      1, 1, 6'b000011, 3'b000, 8'd1, 6'b000011, 6'b000011, 0, 0);
    add("rm_s1",     2, 0, 6'b001100, 3'b000, 8'd1, 6'b000001, 6'b000011, 1, 0);
    add("rm_s2",     1, 0, 6'b001100, 3'b000, 8'd1, 6'b000101, 6'b000011, 1, 0);
    add("rm_rst",    1, 1, 6'b000011, 3'b000, 8'd1, 6'b000011, 6'b000011, 0, 0);
    add("rm_idle",   3, 0, 6'b000011, 3'b000, 8'd1, 6'b000011, 6'b000011, 0, 0);
    add("dmax_s1", 256, 0, 6'b001100, 3'b000, 8'd255, 6'b000001, 6'b000011, 1, 0);
    add("dmax_s2", 256, 0, 6'b001100, 3'b000, 8'd255, 6'b000101, 6'b000011, 1, 0);
    add("dmax_s3", 256, 0, 6'b001100, 3'b000, 8'd255, 6'b000100, 6'b000011, 1, 0);
    add("dmax_done", 1, 0, 6'b001100, 3'b000, 8'd255, 6'b001100, 6'b001100, 0, 1);
    add("dmax_idle", 2, 0, 6'b001100, 3'b000, 8'd255, 6'b001100, 6'b001100, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      bus.vnew  = vecs[i].vnew;
      bus.dir   = vecs[i].dir;
      bus.dwell = vecs[i].dwell;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.vout !== e.vout || bus.vcur !== e.vcur ||
          bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL %s[%0d]: got vout=%b vcur=%b busy=%b done=%b, want vout=%b vcur=%b busy=%b done=%b",
                 e.tag, i, bus.vout, bus.vcur, bus.busy, bus.done,
                 e.vout, e.vcur, e.busy, e.done);
      end
    end

    rst = 1'b1; bus.vnew = 6'b001100; bus.dir = 3'b000; bus.dwell = 8'd0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.vout !== 6'b000011 || bus.vcur !== 6'b000011 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: vout=%b vcur=%b busy=%b done=%b",
               bus.vout, bus.vcur, bus.busy, bus.done);
    end

    rst = 1'b0; bus.vnew = 6'b110000;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_done: timeout waiting for done");
    end else if (bus.vcur !== 6'b110000 || bus.vout !== 6'b110000) begin
      errors++;
      $display("FAIL wait_done: vout=%b vcur=%b want 110000",
               bus.vout, bus.vcur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
